// File: rtl/dac_data_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_data_tx
// Brief    : Dual-channel DAC transmit path: prime-then-play FIFO, 14-bit saturation.
// Revision : 1.0
// ============================================================================
module dac_data_tx #(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 8,
    parameter bit OFFSET_BIN  = 1'b1
) (
    input  logic        dac_clk100m,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] s_data_a,
    input  logic [15:0] s_data_b,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [13:0] dac_data_a,
    output logic [13:0] dac_data_b,
    output logic        dac_clip_a,
    output logic        dac_clip_b,
    output logic        running,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH    = DEPTH[c_AW:0];
    localparam logic [c_AW:0]   c_PTR_ONE  = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW+1:0] c_PRIME    = PRIME_LEVEL[c_AW+1:0];
    localparam logic [13:0]     c_MIDSCALE = OFFSET_BIN ? 14'h2000 : 14'h0000;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_UNDER = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [c_AW:0]   w_count;
    logic [c_AW+1:0] w_level;
    logic [15:0]     r_mem_a [DEPTH];
    logic [15:0]     r_mem_b [DEPTH];
    logic            w_push;
    logic            w_pop;
    logic            w_under_evt;
    logic [14:0]     w_conv_a;
    logic [14:0]     w_conv_b;
    logic [13:0]     r_dac_a;
    logic [13:0]     r_dac_b;
    logic            r_clip_a;
    logic            r_clip_b;
    logic            r_underflow;
    logic [15:0]     r_underflow_cnt;

    // Returns {clip, code}: clip to [-8192, 8191], then optional offset-binary flip.
    function automatic logic [14:0] f_convert(input logic [15:0] d);
        logic        clip;
        logic [13:0] code;
        clip = (d[15:13] != 3'b000) && (d[15:13] != 3'b111);
        code = clip ? {d[15], {13{~d[15]}}} : d[13:0];
        if (OFFSET_BIN) begin
            code[13] = ~code[13];
        end
        return {clip, code};
    endfunction

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign s_ready     = en && (w_count < c_DEPTH) && (r_state != c_ST_IDLE);
    assign w_push      = s_valid && s_ready;
    assign w_pop       = en && (r_state == c_ST_RUN) && (w_count != '0);
    assign w_under_evt = en && (r_state == c_ST_RUN) && (w_count == '0);
    assign w_level     = {1'b0, w_count} + {{(c_AW + 1){1'b0}}, w_push};
    assign w_conv_a    = f_convert(r_mem_a[r_rd_ptr[c_AW-1:0]]);
    assign w_conv_b    = f_convert(r_mem_b[r_rd_ptr[c_AW-1:0]]);

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  w_state_nxt = c_ST_PRIME;
                c_ST_PRIME: if (w_level >= c_PRIME) w_state_nxt = c_ST_RUN;
                // An empty FIFO underflows even if a push lands this cycle.
                c_ST_RUN:   if (w_count == '0) w_state_nxt = c_ST_UNDER;
                c_ST_UNDER: w_state_nxt = c_ST_PRIME;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dac_clk100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!en || (r_state == c_ST_IDLE)) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge dac_clk100m) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[c_AW-1:0]] <= s_data_a;
            r_mem_b[r_wr_ptr[c_AW-1:0]] <= s_data_b;
        end
    end

    always_ff @(posedge dac_clk100m or negedge rst_n) begin
        if (!rst_n) begin
            r_dac_a         <= c_MIDSCALE;
            r_dac_b         <= c_MIDSCALE;
            r_clip_a        <= 1'b0;
            r_clip_b        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_dac_a  <= w_conv_a[13:0];
                r_dac_b  <= w_conv_b[13:0];
                r_clip_a <= w_conv_a[14];
                r_clip_b <= w_conv_b[14];
            end else begin
                r_dac_a  <= c_MIDSCALE;
                r_dac_b  <= c_MIDSCALE;
                r_clip_a <= 1'b0;
                r_clip_b <= 1'b0;
            end
            if (!en) begin
                r_underflow <= 1'b0;
            end else if (w_under_evt) begin
                r_underflow <= 1'b1;
            end
            if (w_under_evt && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end

    assign dac_data_a    = r_dac_a;
    assign dac_data_b    = r_dac_b;
    assign dac_clip_a    = r_clip_a;
    assign dac_clip_b    = r_clip_b;
    assign running       = (r_state == c_ST_RUN);
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_data_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_data_tx
// Brief    : Scoreboard bench for dac_data_tx (offset-binary, full-depth, two's-complement).
// Revision : 1.0
// ============================================================================
module tb_dac_data_tx;

    typedef struct packed {
        logic [13:0] a;
        logic [13:0] b;
        logic        ca;
        logic        cb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en;
    logic [15:0] s_data_a;
    logic [15:0] s_data_b;
    logic        s_valid;
    logic [2:0]  s_ready;
    logic [2:0]  running;
    logic [2:0]  underflow;
    logic [13:0] dac_a [3];
    logic [13:0] dac_b [3];
    logic        clip_a [3];
    logic        clip_b [3];
    logic [15:0] ucnt [3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // 0: default offset-binary, 1: PRIME_LEVEL = DEPTH = 16, 2: two's-complement codes
    dac_data_tx #(.DEPTH(16), .PRIME_LEVEL(8), .OFFSET_BIN(1'b1)) u_dut_ob (
        .dac_clk100m(clk), .rst_n(rst_n), .en(en[0]),
        .s_data_a(s_data_a), .s_data_b(s_data_b), .s_valid(s_valid), .s_ready(s_ready[0]),
        .dac_data_a(dac_a[0]), .dac_data_b(dac_b[0]), .dac_clip_a(clip_a[0]), .dac_clip_b(clip_b[0]),
        .running(running[0]), .underflow(underflow[0]), .underflow_cnt(ucnt[0]));

    dac_data_tx #(.DEPTH(16), .PRIME_LEVEL(16), .OFFSET_BIN(1'b1)) u_dut_full (
        .dac_clk100m(clk), .rst_n(rst_n), .en(en[1]),
        .s_data_a(s_data_a), .s_data_b(s_data_b), .s_valid(s_valid), .s_ready(s_ready[1]),
        .dac_data_a(dac_a[1]), .dac_data_b(dac_b[1]), .dac_clip_a(clip_a[1]), .dac_clip_b(clip_b[1]),
        .running(running[1]), .underflow(underflow[1]), .underflow_cnt(ucnt[1]));

    dac_data_tx #(.DEPTH(16), .PRIME_LEVEL(8), .OFFSET_BIN(1'b0)) u_dut_tc (
        .dac_clk100m(clk), .rst_n(rst_n), .en(en[2]),
        .s_data_a(s_data_a), .s_data_b(s_data_b), .s_valid(s_valid), .s_ready(s_ready[2]),
        .dac_data_a(dac_a[2]), .dac_data_b(dac_b[2]), .dac_clip_a(clip_a[2]), .dac_clip_b(clip_b[2]),
        .running(running[2]), .underflow(underflow[2]), .underflow_cnt(ucnt[2]));

    function automatic logic [14:0] model_chan(input logic [15:0] d, input bit ob);
        int          v;
        logic [31:0] u;
        logic [13:0] code;
        logic        clip;
        v    = $signed(d);
        clip = 1'b0;
        if (v > 8191) begin
            v    = 8191;
            clip = 1'b1;
        end else if (v < -8192) begin
            v    = -8192;
            clip = 1'b1;
        end
        u    = v;
        code = u[13:0];
        if (ob) code = code ^ 14'h2000;
        return {clip, code};
    endfunction

    function automatic exp_t model_pair(input logic [15:0] a, input logic [15:0] b, input bit ob);
        exp_t        e;
        logic [14:0] ra;
        logic [14:0] rb;
        ra   = model_chan(a, ob);
        rb   = model_chan(b, ob);
        e.a  = ra[13:0];
        e.b  = rb[13:0];
        e.ca = ra[14];
        e.cb = rb[14];
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one pair for one edge and records its expected playout code.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input bit ob);
        s_data_a = a;
        s_data_b = b;
        s_valid  = 1'b1;
        sb.push_back(model_pair(a, b, ob));
        tick();
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        en       = 3'b000;
        s_valid  = 1'b0;
        s_data_a = '0;
        s_data_b = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (dac_a[0] !== 14'h2000) begin n_fail++; $display("FAIL reset_dac_a: got %h expected 2000", dac_a[0]); end
        n_checks++; if (dac_b[0] !== 14'h2000) begin n_fail++; $display("FAIL reset_dac_b: got %h expected 2000", dac_b[0]); end
        n_checks++; if (dac_a[2] !== 14'h0000) begin n_fail++; $display("FAIL reset_dac_a_tc: got %h expected 0000", dac_a[2]); end
        n_checks++; if (s_ready !== 3'b000) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 000", s_ready); end
        n_checks++; if (running !== 3'b000) begin n_fail++; $display("FAIL reset_running: got %b expected 000", running); end
        n_checks++; if (underflow !== 3'b000) begin n_fail++; $display("FAIL reset_underflow: got %b expected 000", underflow); end
        n_checks++; if (ucnt[0] !== 16'h0000) begin n_fail++; $display("FAIL reset_ucnt: got %h expected 0000", ucnt[0]); end
        n_checks++; if ({clip_a[0], clip_b[0]} !== 2'b00) begin n_fail++; $display("FAIL reset_clips: got %b expected 00", {clip_a[0], clip_b[0]}); end
    endtask

    task automatic test_prime_run;
        exp_t e;
        en[0] = 1'b1;
        tick();
        n_checks++; if (s_ready[0] !== 1'b1) begin n_fail++; $display("FAIL prime_ready: got %b expected 1", s_ready[0]); end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_checks++; if (running[0] !== 1'b0) begin n_fail++; $display("FAIL prime_early_run: got %b expected 0", running[0]); end
            end
            push_pair(16'(i), 16'(-(i + 1)), 1'b1);
        end
        s_valid = 1'b0;
        n_checks++; if (running[0] !== 1'b1) begin n_fail++; $display("FAIL prime_running: got %b expected 1", running[0]); end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++; if (dac_a[0] !== e.a) begin n_fail++; $display("FAIL run_dac_a[%0d]: got %h expected %h", i, dac_a[0], e.a); end
            n_checks++; if (dac_b[0] !== e.b) begin n_fail++; $display("FAIL run_dac_b[%0d]: got %h expected %h", i, dac_b[0], e.b); end
        end
    endtask

    task automatic test_saturation_underflow;
        exp_t        e;
        logic [15:0] ta [8] = '{16'h7FFF, 16'h1FFF, 16'h0100, 16'hE000, 16'h8000, 16'h0001, 16'h2000, 16'hDFFF};
        logic [15:0] tb [8] = '{16'h8000, 16'h7FFF, 16'h1FFF, 16'h0000, 16'hE000, 16'hDFFF, 16'h2000, 16'h7FFE};
        tick();
        n_checks++; if (dac_a[0] !== 14'h2000) begin n_fail++; $display("FAIL under_mid_a: got %h expected 2000", dac_a[0]); end
        n_checks++; if (underflow[0] !== 1'b1) begin n_fail++; $display("FAIL under_flag: got %b expected 1", underflow[0]); end
        n_checks++; if (ucnt[0] !== 16'd1) begin n_fail++; $display("FAIL under_cnt: got %0d expected 1", ucnt[0]); end
        n_checks++; if (running[0] !== 1'b0) begin n_fail++; $display("FAIL under_running: got %b expected 0", running[0]); end
        tick();
        n_checks++; if ((running[0] !== 1'b0) || (s_ready[0] !== 1'b1)) begin
            n_fail++; $display("FAIL reprime_state: got running=%b ready=%b expected running=0 ready=1", running[0], s_ready[0]);
        end
        for (int i = 0; i < 8; i++) push_pair(ta[i], tb[i], 1'b1);
        s_valid = 1'b0;
        n_checks++; if (running[0] !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b expected 1", running[0]); end
        n_checks++; if (ucnt[0] !== 16'd1) begin n_fail++; $display("FAIL resume_cnt: got %0d expected 1", ucnt[0]); end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++; if ({dac_a[0], dac_b[0]} !== {e.a, e.b}) begin
                n_fail++; $display("FAIL sat_data[%0d]: got a=%h b=%h expected a=%h b=%h", i, dac_a[0], dac_b[0], e.a, e.b);
            end
            n_checks++; if ({clip_a[0], clip_b[0]} !== {e.ca, e.cb}) begin
                n_fail++; $display("FAIL sat_clip[%0d]: got %b expected %b", i, {clip_a[0], clip_b[0]}, {e.ca, e.cb});
            end
        end
        tick();
        n_checks++; if (ucnt[0] !== 16'd2) begin n_fail++; $display("FAIL under_cnt2: got %0d expected 2", ucnt[0]); end
        tick();
    endtask

    task automatic test_en_drop;
        exp_t e;
        for (int i = 0; i < 8; i++) push_pair(16'(100 + i), 16'(-100 - i), 1'b1);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++; if (dac_a[0] !== e.a) begin n_fail++; $display("FAIL drop_pre_a[%0d]: got %h expected %h", i, dac_a[0], e.a); end
        end
        sb.delete();
        en[0] = 1'b0;
        tick();
        n_checks++; if ((running[0] !== 1'b0) || (s_ready[0] !== 1'b0)) begin
            n_fail++; $display("FAIL drop_state: got running=%b ready=%b expected 0 0", running[0], s_ready[0]);
        end
        n_checks++; if ({dac_a[0], dac_b[0]} !== {14'h2000, 14'h2000}) begin
            n_fail++; $display("FAIL drop_mid: got a=%h b=%h expected 2000 2000", dac_a[0], dac_b[0]);
        end
        n_checks++; if ({clip_a[0], clip_b[0]} !== 2'b00) begin n_fail++; $display("FAIL drop_clips: got %b expected 00", {clip_a[0], clip_b[0]}); end
        n_checks++; if (underflow[0] !== 1'b0) begin n_fail++; $display("FAIL drop_underflow: got %b expected 0", underflow[0]); end
        n_checks++; if (ucnt[0] !== 16'd2) begin n_fail++; $display("FAIL drop_cnt_kept: got %0d expected 2", ucnt[0]); end
        en[0] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push_pair(16'(200 + i), 16'(-200 - i), 1'b1);
        n_checks++; if (running[0] !== 1'b0) begin n_fail++; $display("FAIL reprime_from_empty: got %b expected 0", running[0]); end
        for (int i = 3; i < 8; i++) push_pair(16'(200 + i), 16'(-200 - i), 1'b1);
        s_valid = 1'b0;
        n_checks++; if (running[0] !== 1'b1) begin n_fail++; $display("FAIL reprime_running: got %b expected 1", running[0]); end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++; if ({dac_a[0], dac_b[0]} !== {e.a, e.b}) begin
                n_fail++; $display("FAIL reprime_data[%0d]: got a=%h b=%h expected a=%h b=%h", i, dac_a[0], dac_b[0], e.a, e.b);
            end
        end
        en[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   accepts = 0;
        int   budget  = 0;
        int   idx     = 0;
        logic acc;
        en[1] = 1'b1;
        tick();
        s_valid = 1'b1;
        while ((running[1] !== 1'b1) && (budget < 40)) begin
            s_data_a = 16'(idx * 3);
            s_data_b = 16'(-idx);
            acc = s_ready[1];
            tick();
            if (acc) begin
                sb.push_back(model_pair(16'(idx * 3), 16'(-idx), 1'b1));
                accepts++;
                idx++;
            end
            budget++;
        end
        n_checks++; if (running[1] !== 1'b1) begin n_fail++; $display("FAIL full_running: got %b expected 1 within 40 cycles", running[1]); end
        n_checks++; if (accepts != 16) begin n_fail++; $display("FAIL full_accepts: got %0d expected 16", accepts); end
        n_checks++; if (s_ready[1] !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b expected 0", s_ready[1]); end
        for (int k = 0; k < 12; k++) begin
            s_data_a = 16'(idx * 3);
            s_data_b = 16'(-idx);
            acc = s_ready[1];
            if (k > 0) begin
                n_checks++; if (s_ready[1] !== 1'b1) begin n_fail++; $display("FAIL sustain_ready[%0d]: got %b expected 1", k, s_ready[1]); end
            end
            tick();
            if (acc) begin
                sb.push_back(model_pair(16'(idx * 3), 16'(-idx), 1'b1));
                idx++;
            end
            e = sb.pop_front();
            n_checks++; if ({dac_a[1], dac_b[1], running[1]} !== {e.a, e.b, 1'b1}) begin
                n_fail++; $display("FAIL sustain_data[%0d]: got a=%h b=%h run=%b expected a=%h b=%h run=1", k, dac_a[1], dac_b[1], running[1], e.a, e.b);
            end
        end
        s_valid = 1'b0;
        en[1]   = 1'b0;
        tick();
        sb.delete();
    endtask

    task automatic test_twos_comp_reset;
        exp_t        e;
        logic [15:0] ta [8] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFFB, 16'h1000, 16'hF000};
        logic [15:0] tb [8] = '{16'hFFFF, 16'h0000, 16'h0123, 16'hE000, 16'h1FFF, 16'h9000, 16'h0000, 16'h0001};
        en[2] = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) push_pair(ta[i], tb[i], 1'b0);
        s_valid = 1'b0;
        n_checks++; if (running[2] !== 1'b1) begin n_fail++; $display("FAIL tc_running: got %b expected 1", running[2]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_checks++; if ({dac_a[2], dac_b[2], clip_a[2], clip_b[2]} !== {e.a, e.b, e.ca, e.cb}) begin
                n_fail++; $display("FAIL tc_data[%0d]: got a=%h b=%h clip=%b%b expected a=%h b=%h clip=%b%b",
                                   i, dac_a[2], dac_b[2], clip_a[2], clip_b[2], e.a, e.b, e.ca, e.cb);
            end
        end
        rst_n = 1'b0;
        #2;
        n_checks++; if ({dac_a[2], dac_b[2]} !== 28'h0) begin n_fail++; $display("FAIL async_rst_data: got a=%h b=%h expected 0000 0000", dac_a[2], dac_b[2]); end
        n_checks++; if ({clip_a[2], clip_b[2]} !== 2'b00) begin n_fail++; $display("FAIL async_rst_clips: got %b expected 00", {clip_a[2], clip_b[2]}); end
        n_checks++; if ((running[2] !== 1'b0) || (s_ready[2] !== 1'b0)) begin
            n_fail++; $display("FAIL async_rst_state: got running=%b ready=%b expected 0 0", running[2], s_ready[2]);
        end
        n_checks++; if (ucnt[0] !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d expected 0", ucnt[0]); end
        sb.delete();
        en    = 3'b000;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_saturation_underflow();
        test_en_drop();
        test_back_to_back();
        test_twos_comp_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
